// File: rtl/uart_out_if.sv
// uart_out_if: groups the byte-load handshake, the RTS/CTS flow-control pair
// and the serial line of the UART transmitter.
//   BYTEIN - byte to transmit, sampled in the accept cycle only
//   load   - one-cycle send request
//   CTS    - clear-to-send from the remote receiver (asynchronous)
//   TX_D   - serial line, idles high
//   RTS    - request-to-send, high while a byte is pending or in flight
//   busy   - high from the accept edge until the frame completes
//   done   - one-cycle pulse when the stop bit finishes
// master: the side that supplies bytes and CTS. slave: the transmitter.
interface uart_out_if;
  logic [7:0] BYTEIN;
  logic       load;
  logic       CTS;
  logic       TX_D;
  logic       RTS;
  logic       busy;
  logic       done;

  modport master (output BYTEIN, load, CTS, input TX_D, RTS, busy, done);
  modport slave  (input BYTEIN, load, CTS, output TX_D, RTS, busy, done);
endinterface

// File: rtl/uart_out.sv
// uart_out: 8N1 UART transmitter with RTS/CTS flow control.
// A byte loaded while idle is held until the synchronised CTS is high, then
// sent as start bit, 8 data bits LSB first, and one stop bit, each bit lasting
// CLKS_PER_BIT clocks.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   u         - uart_out_if.slave (BYTEIN, load, CTS in; TX_D, RTS, busy, done out)
//   dbg_state - current FSM state (IDLE=0, WAIT_CTS=1, START=2, DATA=3, STOP=4)
// Handshake: load is a request, busy is the inverse of ready. A load is
// accepted on a rising edge only if busy is low at that edge; BYTEIN is
// captured on that same edge. Loads while busy is high are dropped.
module uart_out #(
  parameter int CLKS_PER_BIT = 5200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  uart_out_if.slave  u,
  output logic [2:0] dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CTS = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    baud_cnt, baud_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             tx_q, tx_nxt;
  logic             rts_q, rts_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             settle_q, settle_nxt;
  logic [SYNC_STAGES-1:0] cts_sync;
  logic             cts_s;
  logic             bit_end;

  // CTS crosses from the remote clock domain; only the last stage is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cts_sync <= '0;
    else       cts_sync <= {cts_sync[SYNC_STAGES-2:0], u.CTS};
  end
  assign cts_s = cts_sync[SYNC_STAGES-1];

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      rts_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx_q     <= tx_nxt;
      rts_q    <= rts_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      settle_q <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_idx;
    shreg_nxt  = shreg;
    tx_nxt     = tx_q;
    rts_nxt    = rts_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    settle_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (u.load) begin
          shreg_nxt  = u.BYTEIN;
          busy_nxt   = 1'b1;
          rts_nxt    = 1'b1;
          settle_nxt = 1'b1;
          state_nxt  = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        // settle_q holds the first WAIT_CTS cycle, so with CTS already granted
        // the start bit lands two edges after the accept edge.
        if (cts_s && !settle_q) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          tx_nxt    = shreg[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            // shreg[0] is the bit on the line; the next one is shreg[1].
            shreg_nxt = shreg >> 1;
            tx_nxt    = shreg[1];
            bit_nxt   = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          rts_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign u.TX_D    = tx_q;
  assign u.RTS     = rts_q;
  assign u.busy    = busy_q;
  assign u.done    = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_out.sv
// tb_uart_out: randomized and directed bench for uart_out at 4 clocks/bit.
// A reference receiver collects one line sample per clock for each frame and
// rebuilds the byte from those samples; it is compared with the queue of
// bytes the driver loaded.
module tb_uart_out;
  localparam int CPB   = 4;
  localparam int SYNC  = 2;
  localparam int FRAME = 10 * CPB;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_out_if u();

  uart_out #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .u        (u),
    .dbg_state(dbg_state)
  );

  // CTS comes either from the directed sequence or from the random toggler
  logic cts_man = 1'b1;
  logic cts_rand = 1'b1;
  logic tog_en = 1'b0;
  assign u.CTS = tog_en ? cts_rand : cts_man;

  // scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference receiver
  int   rx_n = -1;
  int   rx_cnt = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  int   ctl_bad = 0;
  logic samp [0:FRAME];

  task automatic check_frame();
    int ferr;
    logic [7:0] got;
    logic [7:0] e;
    ferr = 0;
    got = '0;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < CPB; j++)
        if (samp[k*CPB+j] !== samp[k*CPB]) ferr++;
    if (samp[0] !== 1'b0) ferr++;
    if (samp[9*CPB] !== 1'b1) ferr++;
    for (int k = 0; k < 8; k++) got[k] = samp[(k+1)*CPB];
    chk("framing", ferr, 0);
    chk("frame_ctl", ctl_bad, 0);
    chk("done_end", {u.done, u.busy, u.RTS}, 3'b100);
    chk("exp_avail", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rx_byte", got, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_n = -1;
      end else begin
        if (u.done === 1'b1) done_cnt++;
        if (rx_n < 0) begin
          if (u.TX_D === 1'b0) begin
            rx_n      = 0;
            samp[0]   = 1'b0;
            start_cyc = cyc;
            ctl_bad   = (u.busy !== 1'b1 || u.RTS !== 1'b1 || u.done !== 1'b0) ? 1 : 0;
          end
        end else begin
          rx_n++;
          samp[rx_n] = u.TX_D;
          if (rx_n < FRAME) begin
            if (u.busy !== 1'b1 || u.RTS !== 1'b1 || u.done !== 1'b0) ctl_bad++;
          end else begin
            check_frame();
            done_cyc = cyc;
            rx_cnt++;
            rx_n = -1;
          end
        end
      end
    end
  end

  // random CTS toggler
  initial begin
    forever begin
      @(negedge clk);
      if (tog_en) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        cts_rand = ~cts_rand;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit expect_it);
    u.BYTEIN = b;
    u.load   = 1'b1;
    tick(1);
    acc_cyc  = cyc;
    u.load   = 1'b0;
    u.BYTEIN = 8'($urandom);
    chk("acc_busy_rts", {u.busy, u.RTS}, 2'b11);
    if (expect_it) begin
      exp_q.push_back(b);
      n_acc++;
    end
  endtask

  task automatic poke(input logic [7:0] b);
    u.BYTEIN = b;
    u.load   = 1'b1;
    tick(1);
    u.load   = 1'b0;
    u.BYTEIN = 8'($urandom);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (rx_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("frame_timeout", rx_cnt >= target, 1);
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (rx_n < 0 && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int c0;
    u.BYTEIN = 8'h00;
    u.load   = 1'b0;
    reset    = 1'b1;
    tick(3);
    chk("reset_outputs", {u.TX_D, u.RTS, u.busy, u.done}, 4'b1000);
    reset = 1'b0;
    tick(3);

    // asynchronous reset in the middle of a data bit
    send(8'h00, 1'b0);
    tick(12);
    chk("pre_reset_tx", u.TX_D, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_reset", {u.TX_D, u.RTS, u.busy, u.done}, 4'b1000);
    tick(2);
    reset = 1'b0;
    tick(3);
    send(8'h5A, 1'b1);
    wait_frames(n_acc, 200);

    // single frame with CTS held high
    send(8'hA5, 1'b1);
    wait_frames(n_acc, 200);
    chk("start_lat", start_cyc - acc_cyc, 2);

    // CTS low: byte waits with line idle
    cts_man = 1'b0;
    tick(5);
    send(8'h3C, 1'b1);
    bad = 0;
    repeat (100) begin
      tick(1);
      if ({u.TX_D, u.RTS, u.busy} !== 3'b111) bad++;
    end
    chk("wait_cts_hold", bad, 0);
    cts_man = 1'b1;
    c0 = cyc;
    wait_start(20);
    chk("cts_rise_start", (rx_n >= 0) && (start_cyc - c0 <= SYNC + 1), 1);
    wait_frames(n_acc, 200);

    // ignored load while busy, then back-to-back load on the done cycle
    send(8'h00, 1'b1);
    tick(8);
    poke(8'hFF);
    wait_frames(n_acc, 200);
    send(8'hFF, 1'b1);
    wait_frames(n_acc, 200);
    chk("b2b_start_lat", start_cyc - acc_cyc, 2);

    // CTS dropped during data bit 3 does not disturb the frame
    send(8'h81, 1'b1);
    wait_start(20);
    tick(17);
    cts_man = 1'b0;
    wait_frames(n_acc, 200);
    send(8'h42, 1'b1);
    bad = 0;
    repeat (30) begin
      tick(1);
      if ({u.TX_D, u.RTS, u.busy} !== 3'b111 || rx_n >= 0) bad++;
    end
    chk("held_in_wait_cts", bad, 0);
    cts_man = 1'b1;
    wait_frames(n_acc, 200);

    // random bytes with random CTS
    cts_rand = 1'b1;
    tog_en   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wait_frames(n_acc, 2000);
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
      send(8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 6));
        poke(8'($urandom));
      end
    end
    tog_en  = 1'b0;
    cts_man = 1'b1;
    wait_frames(n_acc, 2000);
    tick(50);
    chk("rx_count", rx_cnt, n_acc);
    chk("done_count", done_cnt, n_acc);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
